// File: rtl/mu0_debug_ctrl.sv
// Host-side debug controller for an MU0 core.
// Provides run/stop/step control, breakpoints and a cycle counter.
module mu0_debug_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int NUM_BP  = 4,
    parameter int HOST_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  host_data_in,
    output logic [DATA_W-1:0]  host_data_out,
    input  logic [HOST_AW-1:0] host_addr,
    input  logic               host_ncs,
    input  logic               host_nwe,
    input  logic               host_nre,
    output logic               dut_clk_en,
    output logic               dut_reset,
    input  logic               dut_fetch,
    input  logic [ADDR_W-1:0]  dut_addr,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_RUNNING  = 2'd1,
        S_STEPPING = 2'd2,
        S_BREAK    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_wr_d;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   r_step_n;
    logic [DATA_W-1:0]   r_step_cnt;
    logic [NUM_BP-1:0]   r_bp_en;
    logic [ADDR_W-1:0]   r_bp_addr [NUM_BP];
    logic [31:0]         r_cyc;
    logic                r_bp_hit;
    logic [2:0]          r_bp_idx;
    logic                r_skip;
    logic [1:0]          r_rst_cnt;

    logic                w_wr;
    logic                w_wr_pulse;
    logic                w_rd;
    logic                w_ctrl_wr;
    logic                w_active;
    logic                w_go_rst;
    logic                w_go_stop;
    logic                w_go_run;
    logic                w_go_step;
    logic                w_clr_cyc;
    logic                w_match;
    logic [2:0]          w_idx;
    logic                w_bp;
    logic                w_step_dec;
    logic [DATA_W-1:0]   w_rdata;

    assign w_wr       = ~host_ncs & ~host_nwe;
    assign w_wr_pulse = w_wr & ~r_wr_d;
    assign w_rd       = ~host_ncs & ~host_nre;
    assign w_ctrl_wr  = w_wr_pulse && (host_addr == '0);
    assign w_active   = (r_state == S_RUNNING) || (r_state == S_STEPPING);

    // Command priority: DUT_RST > STOP > RUN > STEP
    assign w_go_rst  = w_ctrl_wr & host_data_in[3];
    assign w_go_stop = w_ctrl_wr & host_data_in[1] & ~host_data_in[3] & w_active;
    assign w_go_run  = w_ctrl_wr & host_data_in[0] & ~host_data_in[1]
                     & ~host_data_in[3] & ~w_active;
    assign w_go_step = w_ctrl_wr & host_data_in[2] & ~host_data_in[0]
                     & ~host_data_in[1] & ~host_data_in[3] & ~w_active;
    assign w_clr_cyc = w_ctrl_wr & host_data_in[4];

    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (r_bp_en[i] && (dut_addr == r_bp_addr[i])) begin
                w_match = 1'b1;
                w_idx   = 3'(i);
            end
        end
    end

    assign w_bp       = w_match & dut_fetch & w_active & ~r_skip;
    assign dut_clk_en = w_active & ~w_bp & ~reset;
    assign w_step_dec = (r_state == S_STEPPING) & dut_fetch & dut_clk_en;
    assign halted     = ~w_active;
    assign dut_reset  = reset | (r_rst_cnt != 2'd0);
    assign host_data_out = r_dout;

    always_comb begin
        w_next = r_state;
        if (w_go_rst || w_go_stop) begin
            w_next = S_HALTED;
        end else if (w_go_run) begin
            w_next = S_RUNNING;
        end else if (w_go_step) begin
            w_next = S_STEPPING;
        end else if (w_bp) begin
            w_next = S_BREAK;
        end else if (w_step_dec && (r_step_cnt == DATA_W'(1))) begin
            w_next = S_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_HALTED;
            r_wr_d     <= 1'b0;
            r_step_cnt <= '0;
            r_cyc      <= '0;
            r_bp_hit   <= 1'b0;
            r_bp_idx   <= '0;
            r_skip     <= 1'b0;
            r_rst_cnt  <= 2'd1;
        end else begin
            r_state <= w_next;
            r_wr_d  <= w_wr;
            if (w_go_step) begin
                r_step_cnt <= (r_step_n == '0) ? DATA_W'(1) : r_step_n;
            end else if (w_step_dec) begin
                r_step_cnt <= r_step_cnt - DATA_W'(1);
            end
            if (w_clr_cyc) begin
                r_cyc <= '0;
            end else if (dut_clk_en) begin
                r_cyc <= r_cyc + 32'd1;
            end
            if (w_go_run || w_go_step || w_go_rst) begin
                r_bp_hit <= 1'b0;
                r_bp_idx <= '0;
            end else if (w_bp && (w_next == S_BREAK)) begin
                r_bp_hit <= 1'b1;
                r_bp_idx <= w_idx;
            end
            // Let the resumed fetch at the breakpoint address go through once
            if ((r_state == S_BREAK) && (w_next != S_BREAK)) begin
                r_skip <= 1'b1;
            end else if (dut_clk_en) begin
                r_skip <= 1'b0;
            end
            if (w_go_rst) begin
                r_rst_cnt <= 2'd2;
            end else if (r_rst_cnt != 2'd0) begin
                r_rst_cnt <= r_rst_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_n <= DATA_W'(1);
            r_bp_en  <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                r_bp_addr[i] <= '0;
            end
        end else if (w_wr_pulse) begin
            if (host_addr == HOST_AW'(1)) begin
                r_step_n <= host_data_in;
            end
            if (host_addr == HOST_AW'(4)) begin
                r_bp_en <= host_data_in[NUM_BP-1:0];
            end
            for (int i = 0; i < NUM_BP; i++) begin
                if (host_addr == HOST_AW'(8 + i)) begin
                    r_bp_addr[i] <= host_data_in[ADDR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (host_addr)
            HOST_AW'(0): w_rdata = DATA_W'({r_bp_idx, r_bp_hit, r_state});
            HOST_AW'(1): w_rdata = r_step_n;
            HOST_AW'(2): w_rdata = DATA_W'(r_cyc[15:0]);
            HOST_AW'(3): w_rdata = DATA_W'(r_cyc[31:16]);
            HOST_AW'(4): w_rdata = DATA_W'(r_bp_en);
            default:     w_rdata = '0;
        endcase
        for (int i = 0; i < NUM_BP; i++) begin
            if (host_addr == HOST_AW'(8 + i)) begin
                w_rdata = DATA_W'(r_bp_addr[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_rd ? w_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mu0_debug_ctrl.sv
// Directed self-checking bench for mu0_debug_ctrl.
// Inputs change 1ns after rising clk; outputs are sampled mid-cycle.
module tb_mu0_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] host_data_in = '0;
    logic [15:0] host_data_out;
    logic [5:0]  host_addr = '0;
    logic        host_ncs = 1'b1;
    logic        host_nwe = 1'b1;
    logic        host_nre = 1'b1;
    logic        dut_clk_en;
    logic        dut_reset;
    logic        dut_fetch = 1'b0;
    logic [11:0] dut_addr = '0;
    logic        halted;

    int n_chk = 0;
    int n_bad = 0;
    logic [15:0] v;
    int cnt;

    always #5 clk = ~clk;

    mu0_debug_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .host_data_in  (host_data_in),
        .host_data_out (host_data_out),
        .host_addr     (host_addr),
        .host_ncs      (host_ncs),
        .host_nwe      (host_nwe),
        .host_nre      (host_nre),
        .dut_clk_en    (dut_clk_en),
        .dut_reset     (dut_reset),
        .dut_fetch     (dut_fetch),
        .dut_addr      (dut_addr),
        .halted        (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Strobe a write; it lands on the next edge, returns 1ns after it
    task automatic wr_go(input logic [5:0] a, input logic [15:0] d);
        host_addr = a;
        host_data_in = d;
        host_ncs = 1'b0;
        host_nwe = 1'b0;
        @(posedge clk); #1;
        host_ncs = 1'b1;
        host_nwe = 1'b1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        wr_go(a, d);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [5:0] a, output logic [15:0] d);
        host_addr = a;
        host_ncs = 1'b0;
        host_nre = 1'b0;
        @(posedge clk); #1;
        d = host_data_out;
        host_ncs = 1'b1;
        host_nre = 1'b1;
    endtask

    task automatic count_steps(input int n, input bit every2,
                               output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            dut_fetch = every2 ? (i % 2 == 1) : 1'b1;
            #2;
            if (dut_fetch && dut_clk_en) c++;
            @(posedge clk); #1;
        end
        dut_fetch = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_dut_reset", dut_reset, 1);
        check("rst_halted", halted, 1);
        check("rst_clk_en", dut_clk_en, 0);
        check("rst_dout", host_data_out, 0);
        reset = 1'b0;
        #1;
        check("rst_tail_hi", dut_reset, 1);
        @(posedge clk); #1;
        check("rst_tail_lo", dut_reset, 0);
        rd(6'd1, v); check("rst_step_n", v, 16'h0001);
        rd(6'd0, v); check("rst_status", v, 16'h0000);
        rd(6'd4, v); check("rst_bp_en", v, 16'h0000);
        rd(6'd9, v); check("rst_bp_addr1", v, 16'h0000);

        // STOP+STEP+RUN at once while halted: nothing happens
        wr_go(6'd0, 16'h0007);
        check("c07_clk_en0", dut_clk_en, 0);
        @(posedge clk); #1;
        check("c07_clk_en1", dut_clk_en, 0);
        check("c07_halted", halted, 1);
        rd(6'd0, v); check("c07_status", v, 16'h0000);

        // RUN with nwe held low 5 cycles
        host_addr = 6'd0;
        host_data_in = 16'h0001;
        host_ncs = 1'b0;
        host_nwe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("run_hold_clk_en", dut_clk_en, 1);
        end
        host_ncs = 1'b1;
        host_nwe = 1'b1;
        @(posedge clk); #1;
        wr(6'd0, 16'h0002);
        check("run_stop_halted", halted, 1);
        rd(6'd2, v); check("run_cyc_lo", v, 16'd6);
        rd(6'd3, v); check("run_cyc_hi", v, 16'd0);
        #3;
        check("dout_idle", host_data_out, 0);
        wr(6'd0, 16'h0010);
        rd(6'd2, v); check("clr_cyc_lo", v, 16'd0);

        // STEP_N=3, fetch every other cycle
        dut_addr = 12'h100;
        wr(6'd1, 16'd3);
        rd(6'd1, v); check("step_n_rb", v, 16'd3);
        wr_go(6'd0, 16'h0004);
        count_steps(12, 1'b1, cnt);
        check("step3_fetches", cnt, 3);
        check("step3_halted", halted, 1);
        rd(6'd0, v); check("step3_status", v, 16'h0000);

        // STEP_N=0 behaves as 1
        wr(6'd1, 16'd0);
        wr_go(6'd0, 16'h0004);
        count_steps(6, 1'b0, cnt);
        check("step0_fetches", cnt, 1);
        check("step0_halted", halted, 1);

        // Breakpoints: channel 0 has the address but is disabled
        wr(6'd4, 16'h0006);
        wr(6'd8, 16'h0020);
        wr(6'd9, 16'h0020);
        wr(6'd10, 16'h0020);
        rd(6'd4, v); check("bp_en_rb", v, 16'h0006);
        rd(6'd9, v); check("bp_addr1_rb", v, 16'h0020);
        dut_addr = 12'h010;
        dut_fetch = 1'b1;
        wr(6'd0, 16'h0001);
        check("bp_pre_clk_en", dut_clk_en, 1);
        dut_addr = 12'h020;
        #1;
        check("bp_hit_clk_en", dut_clk_en, 0);
        @(posedge clk); #1;
        check("bp_halted", halted, 1);
        check("bp_break_clk_en", dut_clk_en, 0);
        rd(6'd0, v); check("bp_status", v, 16'h000F);
        wr_go(6'd0, 16'h0001);
        #1;
        check("bp_resume_clk_en", dut_clk_en, 1);
        check("bp_resume_halted", halted, 0);
        dut_addr = 12'h022;
        @(posedge clk); #1;
        check("bp_after_clk_en", dut_clk_en, 1);
        rd(6'd0, v); check("bp_clr_status", v, 16'h0001);
        dut_fetch = 1'b0;
        wr(6'd0, 16'h0002);
        check("bp_stop_halted", halted, 1);

        // Cycle counter wrap, then DUT reset pulse
        force dut.r_cyc = 32'hFFFF_FFFE;
        #2;
        release dut.r_cyc;
        rd(6'd2, v); check("pre_cyc_lo", v, 16'hFFFE);
        rd(6'd3, v); check("pre_cyc_hi", v, 16'hFFFF);
        wr(6'd0, 16'h0001);
        wr(6'd0, 16'h0002);
        rd(6'd2, v); check("wrap_cyc_lo", v, 16'h0000);
        rd(6'd3, v); check("wrap_cyc_hi", v, 16'h0000);
        check("drst_before", dut_reset, 0);
        wr_go(6'd0, 16'h0008);
        check("drst_c1", dut_reset, 1);
        @(posedge clk); #1;
        check("drst_c2", dut_reset, 1);
        @(posedge clk); #1;
        check("drst_c3", dut_reset, 0);
        rd(6'd0, v); check("drst_status", v, 16'h0000);

        // Unmapped addresses
        wr(6'd5, 16'hFFFF);
        rd(6'd5, v); check("unmapped_5", v, 16'h0000);
        rd(6'd63, v); check("unmapped_63", v, 16'h0000);

        // Reset during RUNNING
        wr(6'd0, 16'h0001);
        check("abort_running", dut_clk_en, 1);
        reset = 1'b1;
        #1;
        check("abort_clk_en", dut_clk_en, 0);
        @(posedge clk); #1;
        check("abort_halted", halted, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_clk_en2", dut_clk_en, 0);
        rd(6'd4, v); check("abort_bp_en", v, 16'h0000);
        rd(6'd1, v); check("abort_step_n", v, 16'h0001);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/mu0_debug_ctrl.md
MU0_DEBUG_CTRL -- requirements
Module: mu0_debug_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_W, 16, host and DUT data width
- ADDR_W, 12, DUT address width
- NUM_BP, 4, breakpoint channels (1..8)
- HOST_AW, 6, host word-address width
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- host_data_in  in  DATA_W  host write data
- host_data_out  out  DATA_W  host read data
- host_addr  in  HOST_AW  host register word address
- host_ncs  in  1  chip select, active low
- host_nwe  in  1  write enable, active low
- host_nre  in  1  read enable, active low
- dut_clk_en  out  1  DUT advance enable
- dut_reset  out  1  DUT reset
- dut_fetch  in  1  DUT fetch cycle indicator
- dut_addr  in  ADDR_W  DUT memory address
- halted  out  1  high in HALTED or BREAK

Function
REQ-003 All host inputs SHALL be sampled on rising clk; a write SHALL take effect exactly once, on the first cycle where host_ncs=0 and host_nwe=0 (falling-edge detect of the combined strobe).
REQ-004 host_data_out SHALL be registered: it presents the selected register one cycle after host_ncs=0 and host_nre=0, and is 0 otherwise.
REQ-005 Register map, word addresses:
- 0 CTRL (W): bit0 RUN, bit1 STOP, bit2 STEP, bit3 DUT_RST, bit4 CLR_CYC; self-clearing.
- 0 STATUS (R): [1:0] state, [2] bp_hit, [5:3] bp_idx.
- 1 STEP_N (R/W).
- 2 CYC_LO (R).
- 3 CYC_HI (R).
- 4 BP_EN (R/W), bits [NUM_BP-1:0].
- 8..8+NUM_BP-1 BP_ADDR[i] (R/W), low ADDR_W bits.
- Unmapped reads return 0; unmapped writes are ignored.
REQ-006 FSM states and encodings: HALTED=0, RUNNING=1, STEPPING=2, BREAK=3.
REQ-007 Transitions:
- HALTED/BREAK + RUN -> RUNNING.
- HALTED/BREAK + STEP -> STEPPING, step counter loaded with STEP_N (0 treated as 1).
- RUNNING/STEPPING + STOP -> HALTED.
- STEP or RUN while RUNNING/STEPPING is ignored.
REQ-008 Simultaneous CTRL bits: STOP beats RUN beats STEP; DUT_RST beats all and forces HALTED.
REQ-009 dut_clk_en SHALL be combinational: high only in RUNNING/STEPPING and not during a breakpoint match in the same cycle.
REQ-010 Breakpoint match: dut_fetch=1, BP_EN[i]=1, dut_addr==BP_ADDR[i], in RUNNING/STEPPING.
- Match -> next state BREAK, bp_hit=1, bp_idx=lowest matching i.
- The matching fetch SHALL NOT advance (dut_clk_en=0 that cycle).
REQ-011 Skip flag: set on leaving BREAK; suppresses matching for the first enabled cycle only, so resumption from a breakpoint always progresses.
REQ-012 STEPPING: decrement the step counter on each cycle with dut_fetch=1 and dut_clk_en=1; on the decrement to 0, next state HALTED. A breakpoint match in the same cycle takes precedence (BREAK).
REQ-013 Cycle counter: 32 bits, increments every cycle dut_clk_en=1, wraps 0xFFFFFFFF->0. CLR_CYC zeroes it; CLR_CYC concurrent with an increment yields 0.
REQ-014 DUT_RST SHALL drive dut_reset=1 for exactly 2 cycles, starting the cycle after the write; repeat writes during the pulse restart the count.
REQ-015 bp_hit clears on RUN, STEP or DUT_RST.

Reset
REQ-016 Reset outputs and registers: state HALTED, dut_clk_en=0, dut_reset=1 while reset is high and for 1 cycle after, halted=1, host_data_out=0, STEP_N=1, BP_EN=0, BP_ADDR=0, cycle counter 0, bp_hit=0, skip=0.
REQ-017 reset asserted mid-RUNNING or mid-STEPPING SHALL abort to HALTED on the next edge with no further dut_clk_en pulse.

Verification
REQ-018 Write CTRL=0x01 with nwe held low 5 cycles -> single RUNNING entry; dut_clk_en=1 from next cycle; CYC increments by 1 per cycle.
REQ-019 STEP_N=3, CTRL=0x04, fetch every 2nd cycle -> exactly 3 fetch cycles enabled, then HALTED, STATUS=0x0000.
REQ-020 BP_EN=0x6, BP_ADDR[1]=BP_ADDR[2]=0x020, run to fetch at 0x020 -> dut_clk_en=0 that cycle, STATUS state=3, bp_hit=1, bp_idx=1; RUN -> fetch at 0x020 advances, no re-break.
REQ-021 CTRL=0x07 while HALTED -> stays HALTED, no dut_clk_en pulse.
REQ-022 CYC preloaded via run to 0xFFFFFFFF, one more enabled cycle -> CYC_HI=0, CYC_LO=0; CTRL=0x08 -> dut_reset high exactly 2 cycles, state HALTED.
